// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Framed byte-stream loader for the CPU instruction memory.
//                Frame = count header, little-endian 32-bit words, XOR
//                checksum. Holds the CPU until the checksum is verified.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_data_o,
    output logic                  cpu_hold_o,
    output logic                  start_o,
    output logic                  busy_o,
    output logic                  error_o
);

    // Remaining-word counter needs one extra bit so a zero header can mean
    // a full 2^ADDR_WIDTH-word image.
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [2:0] S_HDR   = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]            r_state;
    logic                  r_csum_armed;   // first S_CSUM cycle stalls the stream
    logic [CNT_W-1:0]      r_remaining;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [31:0]           r_word;
    logic [1:0]            r_lane;
    logic [7:0]            r_xor;

    logic                  w_ready_state;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_hdr_count;

    // Ready is a pure state decode; reset forces it low so nothing is
    // offered as accepted while the loader is being cleared.
    always_comb begin
        w_ready_state = (r_state == S_HDR) || (r_state == S_DATA) ||
                        ((r_state == S_CSUM) && r_csum_armed);
        byte_ready_o  = w_ready_state && !rst_i;
        w_accept      = byte_valid_i && byte_ready_o;
    end

    // Header byte to word count: zero selects the whole memory.
    always_comb begin
        w_hdr_count = CNT_W'(byte_data_i);
        if (byte_data_i == 8'd0) begin
            w_hdr_count = CNT_W'(1) << ADDR_WIDTH;
        end
    end

    // Frame parser: header latch, lane assembly, write strobe, checksum verdict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_HDR;
            r_csum_armed <= 1'b0;
            r_remaining  <= '0;
            r_index      <= '0;
            r_word       <= '0;
            r_lane       <= 2'd0;
            r_xor        <= 8'd0;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        r_remaining <= w_hdr_count;
                        r_xor       <= byte_data_i;
                        r_index     <= '0;
                        r_lane      <= 2'd0;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word[{r_lane, 3'b000} +: 8] <= byte_data_i;
                        r_xor <= r_xor ^ byte_data_i;
                        if (r_lane == 2'd3) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_lane <= r_lane + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_index     <= r_index + 1'b1;
                    r_remaining <= r_remaining - CNT_W'(1);
                    r_lane      <= 2'd0;
                    if (r_remaining == CNT_W'(1)) begin
                        r_csum_armed <= 1'b0;
                        r_state      <= S_CSUM;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_CSUM: begin
                    r_csum_armed <= 1'b1;
                    if (w_accept) begin
                        r_state <= (byte_data_i == r_xor) ? S_DONE : S_ERR;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    // Unreachable encodings fall into the safe, CPU-held state.
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    // Memory and CPU-control outputs decoded from registered state only.
    always_comb begin
        imem_we_o   = (r_state == S_WRITE);
        imem_addr_o = r_index;
        imem_data_o = r_word;
        start_o     = (r_state == S_DONE);
        cpu_hold_o  = (r_state != S_DONE);
        busy_o      = (r_state == S_DATA) || (r_state == S_WRITE) ||
                      (r_state == S_CSUM);
        error_o     = (r_state == S_ERR);
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_loader
//  Description : Self-checking bench for imem_boot_loader. Frames are built
//                as byte queues; a frame-level model derives the expected
//                memory writes and final CPU-control flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        cpu_hold;
    logic        start;
    logic        busy;
    logic        error;

    imem_boot_loader #(.ADDR_WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .cpu_hold_o   (cpu_hold),
        .start_o      (start),
        .busy_o       (busy),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          strobe_count = 0;
    logic        strobe_due = 1'b0;
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  frame[$];
    logic [7:0]  cap_addr[0:1023];
    logic [31:0] cap_data[0:1023];
    bit          want_ok;
    int          base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Per-cycle compare: strobe exactly one cycle after a word's 4th byte,
    // ready low while writing, address/data in model order.
    always @(negedge clk) begin : cmp
        int          a;
        logic [31:0] d;
        chk("we_timing", {31'd0, imem_we}, {31'd0, strobe_due});
        if (imem_we) begin
            chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
            chk("strobe_expected", {31'd0, exp_addr.size() != 0}, 32'd1);
            if (exp_addr.size() != 0) begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                chk("imem_addr", {24'd0, imem_addr}, a);
                chk("imem_data", imem_data, d);
            end
            cap_addr[strobe_count & 1023] = imem_addr;
            cap_data[strobe_count & 1023] = imem_data;
            strobe_count++;
        end
        strobe_due = 1'b0;
    end

    function automatic logic [7:0] frame_xor();
        logic [7:0] x = 8'd0;
        for (int i = 0; i < frame.size() - 1; i++) x ^= frame[i];
        return x;
    endfunction

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) frame.push_back(8'((w >> (8 * i)) & 32'hFF));
    endtask

    task automatic close_frame(input logic [7:0] flip);
        logic [7:0] x = 8'd0;
        foreach (frame[i]) x ^= frame[i];
        frame.push_back(x ^ flip);
    endtask

    function automatic int hdr_words();
        return (frame[0] == 8'd0) ? 256 : int'(frame[0]);
    endfunction

    // Frame-level model: every complete word present is written in order,
    // addresses wrap at 256; load succeeds iff the last byte is the XOR.
    task automatic model_frame();
        int n  = hdr_words();
        int nw = (frame.size() - 1) / 4;
        if (nw > n) nw = n;
        for (int k = 0; k < nw; k++) begin
            exp_addr.push_back(k % 256);
            exp_data.push_back({frame[4*k+4], frame[4*k+3], frame[4*k+2], frame[4*k+1]});
        end
        want_ok = (frame_xor() == frame[frame.size() - 1]);
    endtask

    // Push the whole frame through the handshake; returns just after the
    // edge that consumed the last byte.
    task automatic send(input bit rand_valid);
        int  idx = 0;
        int  cyc = 0;
        int  n   = hdr_words();
        int  budget = 4 * frame.size() + 50;
        bit  v, acc;
        @(posedge clk);
        base = strobe_count;
        model_frame();
        while (idx < frame.size()) begin
            @(negedge clk);
            if (cyc++ > budget) begin
                chk("send_timeout", idx, frame.size());
                byte_valid = 1'b0;
                return;
            end
            v = rand_valid ? (($urandom & 1) == 1) : 1'b1;
            byte_valid = v;
            byte_data  = frame[idx];
            acc = v && byte_ready;
            @(posedge clk);
            if (acc) begin
                if (idx >= 1 && idx <= 4 * n && (idx % 4) == 0) strobe_due = 1'b1;
                idx++;
            end
        end
    endtask

    task automatic check_final(input string tag);
        @(negedge clk);
        byte_valid = 1'b0;
        chk({tag, "_start"}, {31'd0, start}, {31'd0, want_ok});
        chk({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, !want_ok});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, !want_ok});
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_all_writes"}, exp_addr.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we",    {31'd0, imem_we}, 32'd0);
        chk("rst_addr",  {24'd0, imem_addr}, 32'd0);
        chk("rst_data",  imem_data, 32'd0);
        chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, byte_ready}, 32'd1);

        // Two-word program, good checksum.
        frame.delete();
        frame.push_back(8'h02);
        add_word(32'h20080005);
        add_word(32'h01084020);
        close_frame(8'h00);
        chk("t1_csum_literal", {24'd0, frame[frame.size() - 1]}, 32'h46);
        send(1'b0);
        check_final("t1");
        @(posedge clk);
        chk("t1_strobes", strobe_count - base, 32'd2);
        chk("t1_word0", cap_data[base & 1023], 32'h20080005);
        chk("t1_addr1", {24'd0, cap_addr[(base + 1) & 1023]}, 32'd1);
        chk("t1_word1", cap_data[(base + 1) & 1023], 32'h01084020);

        // Same frame with a corrupted checksum; nothing further accepted.
        do_reset();
        frame[frame.size() - 1] = frame[frame.size() - 1] ^ 8'h01;
        send(1'b0);
        check_final("t2");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'hA5;
            chk("t2_refuse", {31'd0, byte_ready}, 32'd0);
        end

        // Full-memory image (header 0), incrementing pattern.
        do_reset();
        frame.delete();
        frame.push_back(8'h00);
        for (int i = 0; i < 1024; i++) frame.push_back(8'(i));
        close_frame(8'h00);
        send(1'b0);
        check_final("t3");
        @(posedge clk);
        chk("t3_strobes", strobe_count - base, 32'd256);
        chk("t3_last_addr", {24'd0, cap_addr[(base + 255) & 1023]}, 32'd255);
        chk("t3_last_word", cap_data[(base + 255) & 1023], 32'hFFFEFDFC);

        // Bursty valid, three words.
        do_reset();
        frame.delete();
        frame.push_back(8'h03);
        add_word(32'h11223344);
        add_word(32'hDEADBEEF);
        add_word(32'h0BADF00D);
        close_frame(8'h00);
        send(1'b1);
        check_final("t4");
        @(posedge clk);
        chk("t4_strobes", strobe_count - base, 32'd3);
        chk("t4_word2", cap_data[(base + 2) & 1023], 32'h0BADF00D);

        // Abort an N=4 frame after its 6th data byte.
        do_reset();
        frame.delete();
        frame.push_back(8'h04);
        add_word(32'h89ABCDEF);
        frame.push_back(8'h55);
        frame.push_back(8'h66);
        send(1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("t5_busy_mid", {31'd0, busy}, 32'd1);
        chk("t5_strobes", strobe_count - base, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        chk("t5_start_after", {31'd0, start}, 32'd0);
        chk("t5_hold_after", {31'd0, cpu_hold}, 32'd1);
        frame.delete();
        frame.push_back(8'h01);
        add_word(32'hCAFEF00D);
        close_frame(8'h00);
        send(1'b0);
        check_final("t5b");
        @(posedge clk);
        chk("t5b_addr", {24'd0, cap_addr[base & 1023]}, 32'd0);
        chk("t5b_word", cap_data[base & 1023], 32'hCAFEF00D);

        // Second header after a completed load is refused.
        base = strobe_count;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'h01;
            chk("t6_refuse", {31'd0, byte_ready}, 32'd0);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        chk("t6_no_strobe", strobe_count - base, 32'd0);
        chk("t6_start_kept", {31'd0, start}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream program loader for the pipelined CPU's instruction memory. Accepts a framed byte stream (count header, little-endian instruction words, XOR checksum) over a valid/ready handshake. Writes each assembled 32-bit word into instruction memory one word per write strobe, and holds the CPU stopped until the frame is verified. It then raises the CPU start level, replacing the simulation-only memory preload so programs can be loaded in hardware.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words (256).
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- byte_valid_i  in  1  upstream byte present.
- byte_data_i  in  8  upstream byte.
- byte_ready_o  out  1  loader can accept a byte; transfer occurs on a rising edge with byte_valid_i && byte_ready_o.
- imem_we_o  out  1  one-cycle instruction-memory write strobe.
- imem_addr_o  out  ADDR_WIDTH  word index being written.
- imem_data_o  out  32  assembled instruction word.
- cpu_hold_o  out  1  1 = keep CPU stopped.
- start_o  out  1  level start for the CPU; 1 only after a verified load.
- busy_o  out  1  frame in progress: header accepted, checksum not yet accepted.
- error_o  out  1  checksum mismatch, sticky.

## Operation
- Frame: header byte N (word count; 0 means 2^ADDR_WIDTH words), then 4*N data bytes, then 1 checksum byte.
- Each word is assembled little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
- Checksum is valid when the checksum byte equals the XOR of the header and all data bytes.
- States and transitions:
  - S_HDR: ready=1. On accept, latch N into a (ADDR_WIDTH+1)-bit remaining count (0 maps to 2^ADDR_WIDTH), seed the XOR with the header byte, clear the word index and byte lane, go S_DATA.
  - S_DATA: ready=1. On accept, place the byte in the current lane and XOR it in. On the 4th lane, go S_WRITE; otherwise advance the lane.
  - S_WRITE: ready=0. imem_we_o=1 for this cycle only. Then index+1 and remaining-1. If remaining was 1, go S_CSUM; else clear the lane and go S_DATA.
  - S_CSUM: ready=0 for one cycle while the final write completes, then ready=1. On accept: if the byte matches the XOR, go S_DONE; otherwise go S_ERR.
  - S_DONE: ready=0, cpu_hold_o=0, start_o=1. Exit only via rst_i.
  - S_ERR: ready=0, cpu_hold_o=1, start_o=0, error_o=1. Exit only via rst_i.
- imem_addr_o and imem_data_o are stable throughout the S_WRITE cycle. Outside S_WRITE their values are don't-care, but the strobe is 0.
- Word index wraps naturally. With N=0, exactly 2^ADDR_WIDTH writes occur, to addresses 0..2^ADDR_WIDTH-1.
- byte_valid_i with ready=0 is ignored. The byte is not consumed, and upstream must hold it.

## Timing
- Reset values:
  - state=S_HDR; byte_ready_o=0 while rst_i=1, 1 on the first cycle after rst_i falls.
  - imem_we_o=0, imem_addr_o=0, imem_data_o=0.
  - cpu_hold_o=1, start_o=0, busy_o=0, error_o=0.
- A reset asserted mid-frame aborts the load on that edge. Memory contents already written are left as-is, and the CPU remains held.
- Write latency: imem_we_o rises on the cycle after the edge that accepted a word's 4th byte.
- Throughput: with continuous valid, one data byte per cycle, plus one stall cycle per word (S_WRITE).
- start_o and cpu_hold_o change on the edge after the matching checksum byte is accepted. busy_o falls on that same edge.
- All outputs are registered or decoded from the state register only; there is no combinational path from byte_valid_i or byte_data_i to any output.

## Test plan
- N=2, data 0x20080005, 0x01084020 (bytes 05 00 08 20 20 40 08 01), correct checksum:
  - two strobes: addr 0 -> 0x20080005, addr 1 -> 0x01084020;
  - start_o=1 and cpu_hold_o=0 one cycle after the checksum byte.
- Same frame with the checksum byte XOR'd with 0x01 -> error_o=1, start_o=0, cpu_hold_o=1; further bytes are not accepted.
- N=0, 1024 bytes of incrementing pattern -> 256 strobes at addresses 0..255, last word 0xFFFEFDFC, then S_DONE.
- byte_valid_i toggled randomly 50% with N=3:
  - identical memory image and strobe count;
  - each byte consumed exactly once;
  - ready=0 in every S_WRITE cycle.
- rst_i pulsed after the 6th data byte of an N=4 frame:
  - exactly 1 strobe seen before reset;
  - busy_o=0, start_o=0 after reset;
  - a fresh N=1 frame then loads addr 0 correctly.
- Back-to-back frames without reset -> the second header is refused (ready=0 in S_DONE); no strobes occur.
